counter_run_ctrl: RTL
=====================

Name: counter_run_ctrl

Overview:
Sequencer that owns the 4-bit up/down counter datapath (clear, enable, mode) and runs it to a commanded target value.
- Accepts one run command at a time over a valid/ready handshake.
- Clears the counter, then counts up or down until the counter value equals the target.
- Reports completion status and step count.
- Sits between the control/test layer and the counter, replacing direct poking of counter reset/mode.

Parameters:
- WIDTH, 4, counter value width.
- TIMEOUT, 32, maximum enabled count cycles per run before the run is declared failed; must be ≥ 2**WIDTH.
- STEP_W, $clog2(TIMEOUT+1), width of the step counter and the steps output.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  run command valid.
- cmd_ready  out  1  controller can accept a command.
- cmd_dir  in  1  0 = count up, 1 = count down.
- cmd_target  in  WIDTH  value at which the run stops.
- abort  in  1  terminate the current run.
- cnt_clr  out  1  synchronous clear to counter (count ← 0 at next edge).
- cnt_en  out  1  counter step enable.
- cnt_mode  out  1  counter direction, 0 up / 1 down.
- cnt_val  in  WIDTH  current counter value (registered, wraps modulo 2**WIDTH).
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 = reached target, 01 = aborted, 10 = timeout; held until the next command is accepted.
- steps  out  STEP_W  number of enabled count cycles in the last run; held until the next command is accepted.

Behaviour:
- Reset (async, rst=1), all of the following take effect immediately:
  - state = IDLE.
  - cmd_ready=1; cnt_clr=0; cnt_en=0; cnt_mode=0; busy=0; done=0; status=00; steps=0.
  - Captured dir/target = 0.
- Counter contract: when cnt_clr=1, count ← 0 at the next edge. Otherwise, when cnt_en=1, count ± 1 with wrap. cnt_clr has priority.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready: capture cmd_dir/cmd_target, clear the step counter, reset status to 00, go to CLEAR.
  - abort in IDLE is ignored.
- CLEAR (exactly 1 cycle):
  - cnt_clr=1, cnt_mode=dir, busy=1, cmd_ready=0.
  - Go to RUN; if abort=1 instead, go to DONE with status 01.
- RUN:
  - busy=1, cnt_mode=dir.
  - cnt_en = (cnt_val != target) && !abort. This is combinational (Mealy), so the counter stops exactly on target.
  - The step counter increments on every cycle where cnt_en=1.
  - Exit priority:
    1. abort → DONE, status 01.
    2. cnt_val == target → DONE, status 00.
    3. steps == TIMEOUT-1 with cnt_en=1 → DONE, status 10.
- DONE (exactly 1 cycle):
  - done=1, busy=0, cnt_en=0, cmd_ready=0.
  - Go to IDLE. steps/status stay stable from this cycle onward.
- Latency:
  - Accept to first cnt_en = 2 cycles.
  - Up to target T: T enabled cycles.
  - Down to target T: (2**WIDTH − T) mod 2**WIDTH enabled cycles.
  - done asserts the cycle after the match is observed.
- Target 0: count is 0 right after CLEAR, so RUN lasts 1 cycle with cnt_en=0; steps=0, status 00.
- A command presented while busy is not accepted (cmd_ready=0). The requester holds cmd_valid.
- Reset mid-run: outputs return to reset values immediately; the counter is not cleared by this block until the next run's CLEAR.
- cnt_mode is held at the last dir outside RUN/CLEAR so the counter direction never glitches.

Test Plan:
- Reset, then cmd(dir=0, target=5):
  - cnt_clr pulses 1 cycle.
  - cnt_en high 5 cycles; cnt_val 0→5 then holds.
  - done pulse; status=00, steps=5.
- cmd(dir=1, target=0xC):
  - cnt_val 0→F→E→D→C; cnt_mode=1 throughout.
  - done; status=00, steps=4.
- cmd(dir=0, target=0):
  - cnt_en never asserts.
  - done 3 cycles after accept; steps=0, status=00.
- cmd(dir=0, target=0xF), abort when cnt_val=7:
  - cnt_en drops the same cycle; cnt_val holds 7.
  - done next cycle; status=01, steps=7.
- Counter model with stuck cnt_val=3 and target=9:
  - cnt_en high 32 cycles.
  - done; status=10, steps=32.
- Second cmd_valid held during a run: cmd_ready=0 until IDLE, then accepted. Separately, assert rst mid-RUN: busy=0 and cnt_en=0 immediately; a new cmd works normally afterwards.

Source files
------------

// File: rtl/counter_run_ctrl_if.sv
// counter_run_ctrl_if: bundle between the run sequencer and everything around it.
//   Command side : cmd_valid/cmd_ready handshake, cmd_dir, cmd_target, abort.
//   Counter side : cnt_clr, cnt_en, cnt_mode out to the counter; cnt_val back.
//   Result side  : busy, done pulse, status, steps.
// modport slave  : the sequencer (counter_run_ctrl).
// modport master : the requester plus the counter datapath it controls.
interface counter_run_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [WIDTH-1:0]  cmd_target;
    logic              abort;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_mode;
    logic [WIDTH-1:0]  cnt_val;
    logic              busy;
    logic              done;
    logic [1:0]        status;
    logic [STEP_W-1:0] steps;

    modport slave (
        input  cmd_valid, cmd_dir, cmd_target, abort, cnt_val,
        output cmd_ready, cnt_clr, cnt_en, cnt_mode, busy, done, status, steps
    );

    modport master (
        output cmd_valid, cmd_dir, cmd_target, abort, cnt_val,
        input  cmd_ready, cnt_clr, cnt_en, cnt_mode, busy, done, status, steps
    );
endinterface

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: owns an up/down counter and runs it from zero to a
// commanded target. One command at a time: clear the counter for one cycle,
// step it until cnt_val matches the target (or abort / timeout), then pulse
// done with status and the number of enabled steps.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - counter_run_ctrl_if.slave (command, counter control, result)
// TIMEOUT must be at least 2**WIDTH so a healthy counter always reaches
// any target before the timeout fires.
module counter_run_ctrl #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 32,
    parameter int STEP_W  = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    counter_run_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    localparam logic [1:0]        ST_OK      = 2'b00;
    localparam logic [1:0]        ST_ABORT   = 2'b01;
    localparam logic [1:0]        ST_TIMEOUT = 2'b10;
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(TIMEOUT - 1);

    state_t            state;
    logic              dir_q;
    logic [WIDTH-1:0]  target_q;
    logic              cmd_ready_q;
    logic              cnt_clr_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        status_q;
    logic [STEP_W-1:0] steps_q;

    logic at_target;
    logic cnt_en_c;

    // Enable is Mealy on cnt_val so the counter stops on the exact cycle it
    // shows the target, and drops in the same cycle abort is raised.
    assign at_target = (bus.cnt_val == target_q);
    assign cnt_en_c  = (state == RUN) && !at_target && !bus.abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dir_q       <= 1'b0;
            target_q    <= '0;
            cmd_ready_q <= 1'b1;
            cnt_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= ST_OK;
            steps_q     <= '0;
        end else begin
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        dir_q       <= bus.cmd_dir;
                        target_q    <= bus.cmd_target;
                        steps_q     <= '0;
                        status_q    <= ST_OK;
                        cmd_ready_q <= 1'b0;
                        cnt_clr_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (bus.abort) begin
                        status_q <= ST_ABORT;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_en_c) steps_q <= steps_q + STEP_W'(1);
                    // Timeout only counts when a step is actually taken, so the
                    // final step count equals TIMEOUT.
                    if (bus.abort || at_target || (cnt_en_c && steps_q == STEP_LAST)) begin
                        if (bus.abort)     status_q <= ST_ABORT;
                        else if (at_target) status_q <= ST_OK;
                        else               status_q <= ST_TIMEOUT;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    cmd_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.cnt_en    = cnt_en_c;
    // Direction register is only reloaded on accept, so the counter mode
    // holds the last direction between runs and never glitches.
    assign bus.cnt_mode  = dir_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.status    = status_q;
    assign bus.steps     = steps_q;
endmodule
